// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
`timescale 1ns/1ps
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the PS/2 lines and divider ticks, debounces ps2_clk on the
// 6 us sample enable and emits one bit strobe per filtered falling edge.
`timescale 1ns/1ps
module ps2_line_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic i_clk_6us,
    input  logic i_clk_1020us,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_bit_strobe,
    output logic o_bit_val,
    output logic o_to_tick
);

    logic [1:0]          r_c6_sync;
    logic [1:0]          r_c1020_sync;
    logic [1:0]          r_clk_sync;
    logic [1:0]          r_dat_sync;
    logic                r_c6_prev;
    logic                r_c1020_prev;
    logic [FILT_LEN-1:0] r_hist;
    logic                r_fclk;
    logic                r_strobe;
    logic                r_bit;
    logic                r_to_tick;
    logic                w_sample_tick;

    assign w_sample_tick = r_c6_sync[1] & ~r_c6_prev;

    // PS/2 lines idle high, so their synchronisers and the filter reset high
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_c6_sync    <= 2'b00;
            r_c1020_sync <= 2'b00;
            r_clk_sync   <= 2'b11;
            r_dat_sync   <= 2'b11;
            r_c6_prev    <= 1'b0;
            r_c1020_prev <= 1'b0;
            r_hist       <= '1;
            r_fclk       <= 1'b1;
            r_strobe     <= 1'b0;
            r_bit        <= 1'b0;
            r_to_tick    <= 1'b0;
        end else begin
            r_c6_sync    <= {r_c6_sync[0], i_clk_6us};
            r_c1020_sync <= {r_c1020_sync[0], i_clk_1020us};
            r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync   <= {r_dat_sync[0], i_ps2_data};
            r_c6_prev    <= r_c6_sync[1];
            r_c1020_prev <= r_c1020_sync[1];
            r_to_tick    <= r_c1020_sync[1] & ~r_c1020_prev;
            r_strobe     <= 1'b0;
            if (w_sample_tick) begin
                r_hist <= FILT_LEN'({r_hist, r_clk_sync[1]});
            end
            if (r_hist == '0 && r_fclk) begin
                r_fclk   <= 1'b0;
                r_strobe <= 1'b1;
                r_bit    <= r_dat_sync[1];
            end else if (r_hist == '1) begin
                r_fclk <= 1'b1;
            end
        end
    end

    assign o_bit_strobe = r_strobe;
    assign o_bit_val    = r_bit;
    assign o_to_tick    = r_to_tick;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frame FSM with timeout, plus E0/F0 prefix decoder
// producing one key event per completed scan code.
`timescale 1ns/1ps
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILT_LEN      = 3,
    parameter int unsigned TIMEOUT_TICKS = 2
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       clk_6us,
    input  logic       clk_1020us,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       rx_err,
    output logic       busy
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);

    ps2_state_e      r_state;
    ps2_state_e      w_state_nxt;
    logic            w_strobe;
    logic            w_bit;
    logic            w_to_tick;
    logic            w_to_fire;
    logic            w_accept;
    logic            w_err;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par_ok;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_ext_pend;
    logic            r_brk_pend;
    logic [7:0]      r_key_code;
    logic            r_key_ext;
    logic            r_key_break;
    logic            r_key_valid;
    logic            r_rx_err;
    logic            r_busy;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .i_clk_6us    (clk_6us),
        .i_clk_1020us (clk_1020us),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_bit_strobe (w_strobe),
        .o_bit_val    (w_bit),
        .o_to_tick    (w_to_tick)
    );

    // A strobe in the same cycle as the final tick wins over the timeout
    assign w_to_fire = (r_state != IDLE) && !w_strobe && w_to_tick &&
                       (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge sys_clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_to_fire) begin
            w_state_nxt = IDLE;
        end else if (w_strobe) begin
            case (r_state)
                IDLE:    if (!w_bit) w_state_nxt = DATA;
                DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_accept = 1'b0;
        w_err    = w_to_fire;
        if (r_state == STOP && w_strobe) begin
            w_accept = w_bit & r_par_ok;
            w_err    = ~(w_bit & r_par_ok);
        end
    end

    // Frame datapath and timeout counter
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_par_ok  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (r_state == IDLE || w_strobe) r_to_cnt <= '0;
            else if (w_to_tick)              r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_strobe) begin
                case (r_state)
                    IDLE: r_bit_cnt <= 3'd0;
                    DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    PARITY:  r_par_ok <= ^{r_shift, w_bit};
                    default: ;
                endcase
            end
        end
    end

    // Prefix decoder and registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ext_pend  <= 1'b0;
            r_brk_pend  <= 1'b0;
            r_key_code  <= 8'd0;
            r_key_ext   <= 1'b0;
            r_key_break <= 1'b0;
            r_key_valid <= 1'b0;
            r_rx_err    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_rx_err    <= w_err;
            r_busy      <= (w_state_nxt != IDLE);
            if (w_err) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (w_accept) begin
                if (r_shift == PS2_EXT) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == PS2_BRK) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= r_shift;
                    r_key_ext   <= r_ext_pend;
                    r_key_break <= r_brk_pend;
                    r_ext_pend  <= 1'b0;
                    r_brk_pend  <= 1'b0;
                end
            end
        end
    end

    assign key_code  = r_key_code;
    assign key_ext   = r_key_ext;
    assign key_break = r_key_break;
    assign key_valid = r_key_valid;
    assign rx_err    = r_rx_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: drives PS/2 frames at an 80 us bit period and checks
// key events and errors against a byte-level decoder model.
`timescale 1ns/1ps
module tb_ps2_scan_rx;

    localparam int unsigned QTR = 20000;

    logic       sys_clk    = 1'b0;
    logic       rst        = 1'b1;
    logic       clk_6us    = 1'b0;
    logic       clk_1020us = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       rx_err;
    logic       busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [9:0]  obs_q[$];
    logic [9:0]  exp_q[$];
    int          err_seen = 0;
    int          exp_err  = 0;
    int          both_hi  = 0;
    bit          m_ext    = 1'b0;
    bit          m_brk    = 1'b0;
    longint      t_fall   = 0;

    ps2_scan_rx dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .clk_6us    (clk_6us),
        .clk_1020us (clk_1020us),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .key_valid  (key_valid),
        .rx_err     (rx_err),
        .busy       (busy)
    );

    // sys_clk runs at 1 MHz; the design only reacts to the divider ticks
    always #500    sys_clk    = ~sys_clk;
    always #3000   clk_6us    = ~clk_6us;
    always #510000 clk_1020us = ~clk_1020us;

    always @(negedge sys_clk) begin
        if (key_valid === 1'b1) obs_q.push_back({key_ext, key_break, key_code});
        if (rx_err === 1'b1) err_seen++;
        if (key_valid === 1'b1 && rx_err === 1'b1) both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: prefixes accumulate, any other byte is an event
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bit(input bit v);
        ps2_data = v;
        #(QTR);
        ps2_clk = 1'b0;
        t_fall  = $time;
        #(2 * QTR);
        ps2_clk = 1'b1;
        #(QTR);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        send_bit(stop);
        ps2_data = 1'b1;
        model_byte(b, !par_flip && stop);
    endtask

    task automatic compare(input string tag);
        #(30000);
        chk({tag, ".n_ev"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk({tag, ".ev"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
        chk({tag, ".n_err"}, err_seen, exp_err);
    endtask

    initial begin
        int     e0;
        int     waited;
        longint dt;
        logic   busy_max;
        logic [7:0] b;
        int     kind;
        int     fault;

        repeat (5) @(negedge sys_clk);
        chk("rst.outs", {key_code, key_ext, key_break, key_valid, rx_err, busy}, 0);
        rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        chk("idle.outs", {key_code, key_ext, key_break, key_valid, rx_err, busy}, 0);

        send_frame(8'h1C, 1'b0, 1'b1);
        compare("make");
        chk("make.code", key_code, 8'h1C);

        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        compare("break");
        chk("break.flag", key_break, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        compare("lone");
        chk("lone.flag", key_break, 1'b0);

        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        compare("ext_rel");
        chk("ext_rel.flags", {key_ext, key_break, key_code}, {2'b11, 8'h75});

        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        compare("par_err");
        send_frame(8'h1C, 1'b0, 1'b1);
        compare("par_after");

        // Partial frame then silence: timeout must abort it
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        ps2_data = 1'b1;
        chk("to.busy_mid", busy, 1'b1);
        e0 = err_seen;
        waited = 0;
        while (err_seen == e0 && waited < 3000) begin
            @(negedge sys_clk);
            waited++;
        end
        dt = $time - t_fall;
        chk("to.window", 32'(dt >= 64'd1020000 && dt <= 64'd2080000), 1);
        @(negedge sys_clk);
        chk("to.busy_end", busy, 1'b0);
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        compare("timeout");
        send_frame(8'h1C, 1'b0, 1'b1);
        compare("to_after");

        // 10 us glitch on ps2_clk must not start a frame
        busy_max = 1'b0;
        ps2_clk  = 1'b0;
        repeat (10) @(negedge sys_clk) busy_max |= busy;
        ps2_clk = 1'b1;
        repeat (60) @(negedge sys_clk) busy_max |= busy;
        chk("glitch.busy", busy_max, 1'b0);
        compare("glitch");

        // Reset mid-frame drops the partial byte and the pending break prefix
        send_frame(8'hF0, 1'b0, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        @(negedge sys_clk);
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("midrst.outs", {key_code, key_ext, key_break, key_valid, rx_err, busy}, 0);
        rst = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        compare("midrst");
        send_frame(8'h1C, 1'b0, 1'b1);
        compare("rst_after");

        for (int r = 0; r < 12; r++) begin
            kind  = int'($urandom_range(0, 9));
            fault = int'($urandom_range(0, 7));
            if (kind < 2)      b = 8'hE0;
            else if (kind < 4) b = 8'hF0;
            else               b = 8'($urandom);
            send_frame(b, fault == 0, fault != 1);
            compare("rand");
        end

        chk("both_hi", both_hi, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Receives PS/2 keyboard frames and turns them into decoded key events. It sits directly downstream of the PS/2 tick divider and runs entirely in the sys_clk domain. It does not treat the divider's clk_6us and clk_1020us outputs as clocks: it edge-detects them and uses them as a 6 µs sample enable and a ~1 ms timeout tick. It is the only PS/2 receive path; all downstream logic consumes key_* events from it.

## Interface
- FILT_LEN, 3: consecutive equal 6 µs samples needed before the filtered PS/2 clock changes level.
- TIMEOUT_TICKS, 2: number of clk_1020us rising edges without a bit strobe, while mid-frame, that abort the frame.
- sys_clk  in  1  system clock (50 MHz); all logic is on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- clk_6us  in  1  6 µs-period square wave from the tick divider.
- clk_1020us  in  1  1.02 ms-period square wave from the tick divider.
- ps2_clk  in  1  asynchronous PS/2 clock line.
- ps2_data  in  1  asynchronous PS/2 data line.
- key_code  out  8  last decoded scan code; held until the next key_valid.
- key_ext  out  1  key_code was preceded by E0; held with key_code.
- key_break  out  1  key_code was preceded by F0 (key release); held with key_code.
- key_valid  out  1  one-cycle pulse; the key_* outputs are updated in the same cycle.
- rx_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
- busy  out  1  high while the FSM is not in IDLE.

## Operation
- **Synchronisers.** All four inputs pass through 2-flop synchronisers.
- **Ticks.**
  - sample_tick is the rising edge of synced clk_6us: one sys_clk pulse every 6 µs.
  - to_tick is the rising edge of synced clk_1020us.
- **Clock filter.**
  - On each sample_tick, synced ps2_clk shifts into a FILT_LEN-bit history.
  - The filtered clock goes to 0 when the history is all 0, and to 1 when it is all 1. Otherwise it holds.
  - bit_strobe is the falling edge of the filtered clock. The bit value is synced ps2_data in that same cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: a strobe with bit 0 goes to DATA with bit_cnt=0. A strobe with bit 1 is ignored and the FSM stays in IDLE.
  - DATA: shift right into an 8-bit register (new bit enters the MSB, so the byte ends up LSB-first). bit_cnt wraps after 8 bits and the FSM goes to PARITY.
  - PARITY: latch par_ok = (XOR of the 8 data bits plus the parity bit) == 1, i.e. odd parity. Go to STOP.
  - STOP: if the bit is 1 and par_ok, the byte is accepted. Otherwise pulse rx_err. Go to IDLE either way.
- **Timeout.**
  - A counter counts to_tick while not in IDLE. It is cleared on every bit_strobe and in IDLE.
  - When it reaches TIMEOUT_TICKS: pulse rx_err and return to IDLE.
- **Decoder (accepted bytes).**
  - E0 sets ext_pend and produces no event.
  - F0 sets brk_pend and produces no event.
  - Any other byte pulses key_valid, loads key_code, loads key_ext=ext_pend and key_break=brk_pend, then clears both pending flags.
  - Any rx_err also clears ext_pend and brk_pend.

## Timing
- **Reset values:** key_code=0, key_ext=0, key_break=0, key_valid=0, rx_err=0, busy=0. FSM in IDLE; filter history all 1 and filtered clock 1; counters 0; pending flags 0.
- **Reset mid-frame** discards the partial byte. No pulse is emitted.
- **Latency:**
  - key_valid and rx_err for a stop-bit error are registered: they fire 1 sys_clk cycle after the stop-bit strobe.
  - A timeout rx_err fires 1 cycle after the terminating to_tick.
- **Edge-detect lag:** the filtered clock falls FILT_LEN to FILT_LEN+1 sample_ticks after the line falls (2-cycle synchroniser plus ≤6 µs alignment). This is well inside the ≥30 µs low phase of PS/2.
- **bit_strobe and to_tick in the same cycle:** the strobe wins. The counter clears and the bit is processed.
- **key_valid and rx_err** are never high in the same cycle.
- **Back-to-back frames** need no idle gap beyond the stop bit.
- **Timeout window:** between (TIMEOUT_TICKS−1)×1.02 ms and TIMEOUT_TICKS×1.02 ms after the last strobe.

## Structure
- **Package ps2_pkg:**
  - State enum: IDLE, DATA, PARITY, STOP.
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
- **Sub-module ps2_line_filter** holds:
  - the four synchronisers;
  - sample_tick and to_tick generation;
  - the FILT_LEN debounce;
  - bit_strobe and bit value outputs.
- **Top level** holds the FSM, the timeout counter and the decoder.

## Test plan
In every frame below, the bench drives PS/2 with an 80 µs bit period (40 µs low), with data changing mid-high.
- **Make code.** Frame 0x1C: data bits LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1. Required: one key_valid, key_code=1C, key_ext=0, key_break=0, rx_err never high.
- **Break sequence.** F0 then 1C. Required: exactly one key_valid, with key_code=1C and key_break=1. Then a lone 1C gives key_break=0.
- **Extended release.** E0, F0, 75. Required: one key_valid, key_code=75, key_ext=1, key_break=1.
- **Parity error.** F0, then 1C sent with parity bit 1. Required: one rx_err and no key_valid. A following good 1C gives key_break=0, proving the flags were cleared.
- **Timeout.** Start bit plus 4 data bits, then ps2_clk held high. Required: rx_err within 1.02–2.04 ms, and busy falls. A following 1C then decodes correctly.
- **Glitch and reset.**
  - A 10 µs low pulse on ps2_clk: no strobe and busy stays 0.
  - rst asserted after 5 bits: all outputs 0. The next full 1C frame decodes correctly.
